// File: rtl/system_monitor_arbiter_rr_if.sv
// Bundles the channel request inputs and the UART write handshake of the
// system-monitor round-robin arbiter.
interface system_monitor_arbiter_rr_if #(
  parameter int NUM_CH = 8,
  parameter int ADDR_W = 7
) ();
  logic [NUM_CH-1:0]         channelsNewDataValid;
  logic [NUM_CH-1:0]         channelMask;
  logic                      menuDisabled;
  logic                      uart_tx_busy;
  logic                      write_done;
  logic                      uartDisabled;
  logic [$clog2(NUM_CH)-1:0] tx_channel;
  logic [ADDR_W-1:0]         tx_address;
  logic                      write;
  logic                      timeout;
  logic [NUM_CH-1:0]         pending;

  modport master (
    input  channelsNewDataValid, channelMask, menuDisabled, uart_tx_busy, write_done,
    output uartDisabled, tx_channel, tx_address, write, timeout, pending
  );

  modport slave (
    output channelsNewDataValid, channelMask, menuDisabled, uart_tx_busy, write_done,
    input  uartDisabled, tx_channel, tx_address, write, timeout, pending
  );
endinterface

// File: rtl/system_monitor_arbiter_rr.sv
// Round-robin arbiter with optional interleaved priority channel; one UART
// write/write_done handshake per grant, guarded by a write_done watchdog.
//
//   state | meaning
//   PARK  | UART path disabled, waiting for menu enable or eligible data
//   SCAN  | looking for an eligible pending channel, latches the grant
//   ISSUE | grant held, waiting for uart_tx_busy to drop before the strobe
//   WAIT  | write issued, waiting for write_done or watchdog expiry
module system_monitor_arbiter_rr #(
  parameter int NUM_CH         = 8,
  parameter int ADDR_W         = 7,
  parameter int PRIO_EN        = 1,
  parameter int PRIO_CH        = 2,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                         clk,
  input  logic                         reset_n,
  system_monitor_arbiter_rr_if.master  bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0] CH_PRIO = CH_W'(PRIO_CH);

  typedef enum logic [1:0] {PARK, SCAN, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rst_sync;
  logic              rst_i;
  logic [NUM_CH-1:0] pending_q, elig, rr_elig, clr_v;
  logic [CH_W-1:0]   rr_ptr_q, tx_channel_q, sel_ch, ptr_next;
  logic [ADDR_W-1:0] tx_address_q;
  logic [WD_W-1:0]   watchdog_q;
  logic              prio_due_q, write_q, timeout_q;
  logic              load_ch, issue, done_ok, wd_expire;
  int                idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i = rst_sync[1];

  assign elig = pending_q & bus.channelMask;

  // With interleaving on, the priority channel is served by prio_due; the
  // rotation skips it unless nothing else is eligible, so it cannot stall rr_ptr.
  always_comb begin
    rr_elig = elig;
    if (PRIO_EN != 0) rr_elig[PRIO_CH] = 1'b0;
    sel_ch = '0;
    idx    = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (rr_elig[idx]) sel_ch = CH_W'(idx);
    end
    if ((PRIO_EN != 0) && elig[PRIO_CH] && (prio_due_q || (rr_elig == '0)))
      sel_ch = CH_PRIO;
  end

  always_comb begin
    state_d   = state_q;
    load_ch   = 1'b0;
    issue     = 1'b0;
    done_ok   = 1'b0;
    wd_expire = 1'b0;
    case (state_q)
      PARK:  if (!bus.menuDisabled || (elig != '0)) state_d = SCAN;
      SCAN:  if (elig != '0) begin
               load_ch = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: if (!bus.uart_tx_busy) begin
               issue   = 1'b1;
               state_d = WAIT;
             end
      WAIT:  if (bus.write_done) begin
               done_ok = 1'b1;
               state_d = bus.menuDisabled ? PARK : SCAN;
             end else if (watchdog_q == WD_LAST) begin
               wd_expire = 1'b1;
               state_d   = SCAN;
             end
      default: state_d = PARK;
    endcase
  end

  always_comb begin
    clr_v = '0;
    if (done_ok) clr_v[tx_channel_q] = 1'b1;
  end

  assign ptr_next = (tx_channel_q == CH_LAST) ? '0 : tx_channel_q + CH_W'(1);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= PARK;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      prio_due_q   <= 1'b0;
      tx_channel_q <= '0;
      tx_address_q <= '0;
      write_q      <= 1'b0;
      timeout_q    <= 1'b0;
      watchdog_q   <= '0;
    end else begin
      state_q   <= state_d;
      write_q   <= issue;
      timeout_q <= wd_expire;
      pending_q <= (pending_q & ~clr_v) | bus.channelsNewDataValid;
      if (load_ch) tx_channel_q <= sel_ch;
      if (issue) begin
        tx_address_q <= ADDR_W'(tx_channel_q);
        watchdog_q   <= '0;
      end else if (state_q == WAIT) begin
        watchdog_q <= watchdog_q + WD_W'(1);
      end
      if (done_ok || wd_expire) begin
        if ((PRIO_EN != 0) && (tx_channel_q == CH_PRIO)) begin
          prio_due_q <= 1'b0;
        end else begin
          rr_ptr_q   <= ptr_next;
          prio_due_q <= 1'b1;
        end
      end
    end
  end

  assign bus.uartDisabled = (state_q == PARK);
  assign bus.tx_channel   = tx_channel_q;
  assign bus.tx_address   = tx_address_q;
  assign bus.write        = write_q;
  assign bus.timeout      = timeout_q;
  assign bus.pending      = pending_q;
endmodule

// File: tb/tb_system_monitor_arbiter_rr.sv
// Bench for system_monitor_arbiter_rr: grant-order vectors against a
// write scoreboard, plus busy, set-wins, timeout and park/reset sequences.
module tb_system_monitor_arbiter_rr;
  localparam int NUM_CH = 8;
  localparam int ADDR_W = 7;
  localparam int TMO    = 8;

  typedef struct {
    logic [7:0]  pulses;
    logic [7:0]  mask;
    int          n;
    logic [31:0] seq;       // expected grant order, one nibble per grant, first in [3:0]
    logic [7:0]  exp_pend;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  system_monitor_arbiter_rr_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();

  system_monitor_arbiter_rr #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PRIO_EN(1), .PRIO_CH(2), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [2:0]  exp_q[$];
  int          arm = 0;
  bit          auto_done = 1'b1;
  logic        prev_write = 1'b0;
  vec_t        vecs[7];
  logic [31:0] seqv;
  logic [2:0]  fair_order[16];
  int          cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=no_event required=event_within_bound", name);
  endtask

  // One clock: sample outputs just after the edge, score writes, then drive write_done.
  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (bus.write === 1'b1) begin
      check("write_single_cycle", {31'd0, prev_write}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: actual=addr %0d required=no write", bus.tx_address);
      end else begin
        e = exp_q.pop_front();
        check("tx_address", {25'd0, bus.tx_address}, {29'd0, e});
        check("tx_channel", {29'd0, bus.tx_channel}, {29'd0, e});
      end
      if (auto_done) arm = 3;
    end
    prev_write = bus.write;
    bus.write_done = 1'b0;
    if (arm > 0) begin
      arm--;
      if (arm == 0) bus.write_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    arm = 0;
    bus.write_done = 1'b0;
    bus.channelsNewDataValid = '0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (4) step();
  endtask

  task automatic wait_queue(input string name, input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      expired(name);
      exp_q.delete();
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || arm != 0 || bus.write_done) && k < limit) begin
      step();
      k++;
    end
    if (exp_q.size() != 0 || arm != 0) begin
      expired(name);
      exp_q.delete();
    end
    repeat (3) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{8'h29, 8'hFF, 3, 32'h0000_0530, 8'h00};
    vecs[1] = '{8'h46, 8'hFF, 3, 32'h0000_0162, 8'h00};
    vecs[2] = '{8'h91, 8'hEF, 2, 32'h0000_0007, 8'h10};
    vecs[3] = '{8'h0C, 8'hFF, 3, 32'h0000_0324, 8'h00};
    vecs[4] = '{8'h04, 8'hFF, 1, 32'h0000_0002, 8'h00};
    vecs[5] = '{8'h24, 8'hFF, 2, 32'h0000_0025, 8'h00};
    vecs[6] = '{8'h04, 8'hFF, 1, 32'h0000_0002, 8'h00};
    fair_order = '{3'd0, 3'd2, 3'd1, 3'd2, 3'd3, 3'd2, 3'd4, 3'd2,
                   3'd5, 3'd2, 3'd6, 3'd2, 3'd7, 3'd2, 3'd0, 3'd2};

    bus.channelsNewDataValid = '0;
    bus.channelMask = 8'hFF;
    bus.menuDisabled = 1'b0;
    bus.uart_tx_busy = 1'b0;
    bus.write_done = 1'b0;

    // Reset state, sampled while reset is held.
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_uartDisabled", {31'd0, bus.uartDisabled}, 32'd1);
    check("rst_pending", {24'd0, bus.pending}, 32'd0);
    check("rst_write", {31'd0, bus.write}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    check("rst_tx_address", {25'd0, bus.tx_address}, 32'd0);
    check("rst_tx_channel", {29'd0, bus.tx_channel}, 32'd0);
    reset_n = 1'b1;
    repeat (4) step();
    check("scan_uartDisabled", {31'd0, bus.uartDisabled}, 32'd0);

    // Grant-order vectors; arbiter history carries from one vector to the next.
    for (int v = 0; v < 7; v++) begin
      bus.channelMask = vecs[v].mask;
      bus.channelsNewDataValid = vecs[v].pulses;
      seqv = vecs[v].seq;
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(seqv[4*i +: 3]);
      step();
      bus.channelsNewDataValid = '0;
      wait_drain("vec_drain", 300);
      check("vec_pending", {24'd0, bus.pending}, {24'd0, vecs[v].exp_pend});
    end

    // Every channel kept re-pending: priority interleave, channel 7 still served.
    do_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(fair_order[i]);
    bus.channelsNewDataValid = 8'hFF;
    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
        step();
        k++;
      end
      if (exp_q.size() != 0) begin
        expired("fair_order");
        exp_q.delete();
      end
    end
    bus.channelsNewDataValid = '0;
    do_reset();

    // uart_tx_busy holds the grant in ISSUE.
    bus.uart_tx_busy = 1'b1;
    bus.channelsNewDataValid = 8'h02;
    exp_q.push_back(3'd1);
    step();
    bus.channelsNewDataValid = '0;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      step();
      check("busy_no_write", {31'd0, bus.write}, 32'd0);
    end
    bus.uart_tx_busy = 1'b0;
    step();
    check("write_after_busy", {31'd0, bus.write}, 32'd1);
    wait_drain("busy_drain", 100);
    check("busy_pending", {24'd0, bus.pending}, 32'd0);

    // New data for channel 4 coincides with its write_done: set wins.
    do_reset();
    auto_done = 1'b0;
    bus.channelsNewDataValid = 8'h10;
    exp_q.push_back(3'd4);
    exp_q.push_back(3'd4);
    step();
    bus.channelsNewDataValid = '0;
    begin
      int k;
      k = 0;
      while (exp_q.size() != 1 && k < 20) begin
        step();
        k++;
      end
      if (exp_q.size() != 1) expired("setwins_first_write");
    end
    repeat (2) step();
    bus.write_done = 1'b1;
    bus.channelsNewDataValid = 8'h10;
    step();
    bus.channelsNewDataValid = '0;
    check("setwins_pending4", {31'd0, bus.pending[4]}, 32'd1);
    auto_done = 1'b1;
    wait_drain("setwins_drain", 100);
    check("setwins_final_pending", {24'd0, bus.pending}, 32'd0);

    // Watchdog expiry with write_done withheld.
    do_reset();
    auto_done = 1'b0;
    bus.channelsNewDataValid = 8'h28;
    exp_q.push_back(3'd3);
    step();
    bus.channelsNewDataValid = '0;
    wait_queue("timeout_write", 20);
    cnt = 0;
    while (cnt < 20) begin
      step();
      cnt++;
      if (bus.timeout === 1'b1) break;
    end
    check("timeout_latency", cnt, TMO);
    check("timeout_pending_kept", {24'd0, bus.pending}, 32'h28);
    auto_done = 1'b1;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd3);
    step();
    check("timeout_single_pulse", {31'd0, bus.timeout}, 32'd0);
    wait_drain("timeout_drain", 100);
    check("timeout_final_pending", {24'd0, bus.pending}, 32'd0);

    // Park behaviour with menuDisabled.
    bus.menuDisabled = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check("park_idle", {31'd0, bus.uartDisabled}, 32'd1);
    end
    bus.channelsNewDataValid = 8'h40;
    exp_q.push_back(3'd6);
    step();
    bus.channelsNewDataValid = '0;
    wait_drain("park_drain", 100);
    for (int i = 0; i < 3; i++) begin
      step();
      check("park_after_done", {31'd0, bus.uartDisabled}, 32'd1);
    end
    bus.menuDisabled = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("unpark", {31'd0, bus.uartDisabled}, 32'd0);
    end

    // Asynchronous reset during WAIT.
    auto_done = 1'b0;
    bus.channelsNewDataValid = 8'h12;
    exp_q.push_back(3'd1);
    step();
    bus.channelsNewDataValid = '0;
    wait_queue("async_write_seen", 20);
    check("pre_reset_write", {31'd0, bus.write}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_write", {31'd0, bus.write}, 32'd0);
    check("async_pending", {24'd0, bus.pending}, 32'd0);
    check("async_uartDisabled", {31'd0, bus.uartDisabled}, 32'd1);
    auto_done = 1'b1;
    do_reset();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/system_monitor_arbiter_rr.md
Name: system_monitor_arbiter_rr

Overview:
- Parametrised successor to the system-monitor UART channel arbiter.
- Collects per-channel "new data" pulses into sticky pending flags and picks one pending channel at a time. Rotation is fair (round-robin from a rotating pointer), with an optional interleaved priority channel.
- Runs one write/write_done handshake per grant to the UART framer. A write_done watchdog guarantees forward progress.
- Sits between the monitor data sources and the shared UART TX path.

Parameters:
- NUM_CH, 8, number of request channels (2..32).
- ADDR_W, 7, width of tx_address; the channel index is zero-extended into it.
- PRIO_EN, 1, 1 = interleave PRIO_CH after every non-priority grant; 0 = pure round-robin.
- PRIO_CH, 2, index of the interleaved priority channel (< NUM_CH).
- TIMEOUT_CYCLES, 4095, number of cycles WAIT tolerates without write_done before aborting (>= 2).

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- channelsNewDataValid, in, NUM_CH, per-channel one-cycle new-data pulse.
- channelMask, in, NUM_CH, 1 = channel eligible for grant; masked channels still latch pending.
- menuDisabled, in, 1, park the arbiter after the current write.
- uart_tx_busy, in, 1, the UART cannot accept a write.
- write_done, in, 1, one-cycle completion of the outstanding write.
- uartDisabled, out, 1, high while parked or in reset.
- tx_channel, out, $clog2(NUM_CH), currently granted channel.
- tx_address, out, ADDR_W, registered address of the issued write.
- write, out, 1, one-cycle write strobe.
- timeout, out, 1, one-cycle pulse when a write is aborted by the watchdog.
- pending, out, NUM_CH, current sticky pending flags (debug/status).

Behaviour:
- Reset (async assert, sync release) clears the following:
  - pending=0, rr_ptr=0, prio_due=0, tx_channel=0, tx_address=0, write=0, timeout=0, watchdog=0.
  - State=PARK, so uartDisabled=1.
- Pending flags:
  - pending[i] is set on channelsNewDataValid[i].
  - It is cleared on write_done while in WAIT with tx_channel==i.
  - If the set and the clear happen in the same cycle, set wins and the channel is re-served later.
- Eligibility: elig = pending & channelMask.
- Selection is combinational and registered on the state transition:
  - If PRIO_EN, prio_due=1, and elig[PRIO_CH]: choose PRIO_CH.
  - Otherwise choose the first elig bit searching upward from rr_ptr, wrapping from NUM_CH-1 to 0.
- State PARK:
  - uartDisabled=1.
  - Go to SCAN next cycle when menuDisabled=0 or any elig bit is set.
- State SCAN:
  - uartDisabled=0.
  - If elig==0, stay in SCAN.
  - Else latch the selected channel into tx_channel and go to ISSUE.
- State ISSUE:
  - While uart_tx_busy=1, hold in ISSUE with write=0.
  - Otherwise, next cycle: write=1 for exactly one cycle, tx_address=zero-extended tx_channel, watchdog cleared, go to WAIT.
- State WAIT:
  - write=0 and the watchdog increments every cycle.
  - On write_done:
    - Clear pending[tx_channel] (subject to set-wins).
    - If tx_channel==PRIO_CH: prio_due<=0. Otherwise rr_ptr<=tx_channel+1 (wrap to 0 at NUM_CH) and prio_due<=1.
    - Then go to PARK if menuDisabled=1, else to SCAN.
  - Timeout, i.e. watchdog reaches TIMEOUT_CYCLES-1 with no write_done:
    - timeout pulses for 1 cycle.
    - pending is kept.
    - rr_ptr advances as above, so the faulted channel goes to the back of the rotation.
    - Go to SCAN.
  - write_done outside WAIT is ignored.
- Latency: the first write strobe comes 2 cycles after SCAN sees an elig bit (SCAN->ISSUE->write), given uart_tx_busy=0.
- If a mask bit clears after the channel is granted, the grant completes normally.
- tx_channel is stable from ISSUE through the end of WAIT.
- Width rules:
  - rr_ptr and tx_channel are $clog2(NUM_CH) bits; wrap is explicit, so NUM_CH need not be a power of 2.
  - The watchdog is $clog2(TIMEOUT_CYCLES+1) bits.

Test Plan:
- Reset, then pulse channels 0, 3 and 5 with PRIO_EN=0 → writes with tx_address 0, 3, 5 in order, each exactly one write cycle; pending returns to 0.
- PRIO_EN=1, PRIO_CH=2, all 8 channels kept re-pending → grant order 0, 2, 1, 2, 3, 2, 4, 2, ... with no starvation of channel 7.
- uart_tx_busy held high for 10 cycles in ISSUE → no write during those cycles; write is asserted the cycle after busy drops.
- channelsNewDataValid[4] pulses in the same cycle as write_done for channel 4 → pending[4] remains 1 and channel 4 is granted again.
- TIMEOUT_CYCLES=8 and write_done withheld → timeout pulses 8 cycles after the write, pending kept, next grant goes to the following eligible channel.
- menuDisabled=1 during WAIT → after write_done, uartDisabled=1. It stays 1 while no elig bit is set and stays 0 after menuDisabled drops. An async reset_n asserted mid-WAIT clears write and pending immediately.
